// File: rtl/mio_bus_bridge.sv
// mio_bus_bridge: SCPU MIO bridge to sync-read data memory, GPIO and compare timer.
// Define MIO_BUS_ERR_EN for a sticky bus_err flag and 32'hDEAD_BEEF unmapped reads.
module mio_bus_bridge #(
  parameter int          ADDR_W  = 10,
  parameter int          GPIO_W  = 16,
  parameter logic [31:0] IO_BASE = 32'hF000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic [GPIO_W-1:0] gpio_in_i,
  output logic [GPIO_W-1:0] gpio_out_o,
  output logic              timer_irq_o,
  output logic              bus_err_o
);
  typedef enum logic [1:0] {IDLE, MEM_RD, RESP} state_t;
`ifdef MIO_BUS_ERR_EN
  localparam logic [31:0] UNM_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNM_RDATA = 32'h0;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d, count_q, count_d, compare_q, compare_d, io_rdata;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic irq_q, irq_d, err_q, err_d;
  logic go, is_mem, is_io, wr_io, unused_addr;
  logic [1:0] sel;
  assign unused_addr = ^cpu_addr_i[1:0];
  assign go     = state_q == IDLE && cpu_req_i;
  assign is_mem = cpu_addr_i[31:ADDR_W+2] == '0;
  assign is_io  = cpu_addr_i[31:4] == IO_BASE[31:4];
  assign sel    = cpu_addr_i[3:2];
  assign wr_io  = go && cpu_we_i && is_io;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (cpu_req_i ? ((is_mem && !cpu_we_i) ? MEM_RD : RESP) : IDLE) :
              (state_q == MEM_RD) ? RESP : IDLE;
  end
  always_comb begin
    cpu_ready_o = state_q == RESP;
    mem_we_o    = !rst && go && cpu_we_i && is_mem;
    mem_addr_o  = (state_q == IDLE) ? cpu_addr_i[ADDR_W+1:2] : addr_q;
  end
  always_comb begin
    io_rdata  = is_io ? (sel[1] ? (sel[0] ? compare_q : count_q)
                                : {{(32-GPIO_W){1'b0}}, sel[0] ? gpio_in_i : gpio_q}) : UNM_RDATA;
    rdata_d   = (state_q == MEM_RD) ? mem_rdata_i : (go && !cpu_we_i && !is_mem) ? io_rdata : rdata_q;
    addr_d    = go ? cpu_addr_i[ADDR_W+1:2] : addr_q;
    gpio_d    = (wr_io && sel == 2'd0) ? cpu_wdata_i[GPIO_W-1:0] : gpio_q;
    count_d   = (wr_io && sel == 2'd2) ? cpu_wdata_i : count_q + 32'd1;
    compare_d = (wr_io && sel == 2'd3) ? cpu_wdata_i : compare_q;
    // Compare against next COUNT so irq is high in the cycle COUNT equals COMPARE; COMPARE write clears.
    irq_d     = !(wr_io && sel == 2'd3) && (irq_q || (count_d == compare_q && compare_q != '0));
`ifdef MIO_BUS_ERR_EN
    err_d     = err_q || (go && !is_mem && !is_io);
`else
    err_d     = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      rdata_q   <= '0;
      gpio_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      gpio_q    <= gpio_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
    end
  end
  assign cpu_rdata_o = rdata_q;
  assign mem_wdata_o = cpu_wdata_i;
  assign gpio_out_o  = gpio_q;
  assign timer_irq_o = irq_q;
  assign bus_err_o   = err_q;
endmodule

// File: tb/tb_mio_bus_bridge.sv
// tb_mio_bus_bridge: scoreboard bench for mio_bus_bridge with a sync-read memory model.
module tb_mio_bus_bridge;
  localparam logic [31:0] IO = 32'hF000_0000;
`ifdef MIO_BUS_ERR_EN
  localparam logic [31:0] UNM = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] UNM = 32'h0;
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif
  typedef struct {bit rd; logic [31:0] d;} sb_t;
  logic clk, rst, cpu_req, cpu_we, cpu_ready, mem_we, timer_irq, bus_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_addr, we_addr;
  logic [15:0] gpio_in, gpio_out;
  logic [31:0] mem [1024];
  sb_t sb[$];
  sb_t e;
  int tests, fails, we_cnt, rdy_cnt, w0, r0;

  mio_bus_bridge dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .timer_irq_o(timer_irq), .bus_err_o(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
    end
    if (cpu_ready) begin
      rdy_cnt++;
      if (sb.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        if (e.rd) chk("rdata", cpu_rdata, e.d);
      end
    end
  end

  task automatic acc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input int exp_lat, input string tag);
    int lat;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    sb.push_back('{rd: !we, d: exp_rd});
    lat = 0;
    while (lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (cpu_ready) break;
    end
    cpu_req = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    tests = 0; fails = 0; we_cnt = 0; rdy_cnt = 0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; gpio_in = 16'h5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_gpio", gpio_out, 0);
    chk("rst_irq", timer_irq, 0);
    chk("rst_err", bus_err, 0);
    rst = 1'b0;
    acc(0, IO + 8, 0, 32'd1, 1, "count_rst");
    // memory write/read, including the last word and the first unmapped word
    w0 = we_cnt;
    acc(1, 32'h40, 32'h1234_5678, 0, 1, "mem_wr");
    chk("mem_we_pulses", we_cnt - w0, 1);
    chk("mem_we_addr", we_addr, 10'h10);
    acc(0, 32'h40, 0, 32'h1234_5678, 2, "mem_rd");
    acc(1, 32'hFFC, 32'hA5A5_0FFC, 0, 1, "top_wr");
    acc(0, 32'hFFC, 0, 32'hA5A5_0FFC, 2, "top_rd");
    chk("err_clean", bus_err, 0);
    w0 = we_cnt;
    acc(1, 32'h1000, 32'h0BAD, 0, 1, "unm_wr");
    chk("unm_no_we", we_cnt - w0, 0);
    acc(0, 32'h1000, 0, UNM, 1, "unm_rd");
    // GPIO
    acc(1, IO, 32'h1234_ABCD, 0, 1, "gpio_wr");
    chk("gpio_out", gpio_out, 16'hABCD);
    acc(1, IO + 4, 32'hFFFF, 0, 1, "gpioin_wr");
    chk("gpio_keep", gpio_out, 16'hABCD);
    acc(0, IO + 4, 0, 32'h0000_5A5A, 1, "gpioin_rd");
    acc(0, IO, 0, 32'h0000_ABCD, 1, "gpio_rd");
    acc(0, IO + 32'h10, 0, UNM, 1, "io_gap_rd");
    // timer wrap and compare interrupt
    acc(1, IO + 8, 32'hFFFF_FFFE, 0, 1, "cnt_wr");
    acc(1, IO + 12, 32'd3, 0, 1, "cmp_wr");
    chk("irq_pre", timer_irq, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("irq_rise", timer_irq, (i == 3) ? 32'd1 : 32'd0);
    end
    acc(0, IO + 8, 0, 32'd4, 1, "cnt_rd");
    repeat (2) @(negedge clk);
    chk("irq_hold", timer_irq, 1);
    acc(0, IO + 12, 0, 32'd3, 1, "cmp_rd");
    chk("irq_hold2", timer_irq, 1);
    acc(1, IO + 12, 32'd0, 0, 1, "cmp_clr");
    chk("irq_clr", timer_irq, 0);
    // request held high across RESP: three accesses in six cycles
    w0 = we_cnt; r0 = rdy_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFE_F00D;
    repeat (3) sb.push_back('{rd: 1'b0, d: 32'h0});
    repeat (6) @(negedge clk);
    cpu_req = 1'b0;
    chk("held_we", we_cnt - w0, 3);
    chk("held_rdy", rdy_cnt - r0, 3);
    acc(0, 32'h80, 0, 32'hCAFE_F00D, 2, "held_rd");
    // reset in the middle of a memory read
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    r0 = rdy_cnt;
    @(negedge clk);
    chk("mid_rst_rdy", cpu_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", rdy_cnt - r0, 0);
    chk("post_rst_rdata", cpu_rdata, 0);
    chk("post_rst_gpio", gpio_out, 0);
    chk("post_rst_err", bus_err, 0);
    acc(0, IO, 0, 32'h0, 1, "post_rst");
    // unmapped high address and sticky error flag
    acc(0, 32'h8000_0000, 0, UNM, 1, "unm_hi");
    chk("err_set", bus_err, EXP_ERR);
    acc(0, IO + 4, 0, 32'h0000_5A5A, 1, "after_err");
    chk("err_sticky", bus_err, EXP_ERR);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
